// File: rtl/adder_pkg.sv
// adder_pkg: shared types and defaults for the bit-serial adder
package adder_pkg;
   localparam int ADDER_WIDTH = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;
endpackage

// File: rtl/adder_serial_if.sv
// adder_serial_if: start/busy/done operation handshake with operands and result
interface adder_serial_if import adder_pkg::*; #(parameter int WIDTH = ADDER_WIDTH);
   logic             start, sub, ci, busy, done, co;
   logic [WIDTH-1:0] a, b, s;
   modport master(output start, sub, a, b, ci, input busy, done, s, co);
   modport slave(input start, sub, a, b, ci, output busy, done, s, co);
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_serial.sv
// adder_serial: LSB-first bit-serial adder/subtractor reusing one full-adder cell
module adder_serial import adder_pkg::*; #(parameter int WIDTH = ADDER_WIDTH) (
   input logic          clk,
   input logic          reset,
   adder_serial_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   serial_state_t    state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, fa_s, fa_co;
   full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(fa_s), .co(fa_co));
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.ci;
            cnt_d   = '0;
            s_d     = '0;
            state_d = RUN;
         end
         RUN: begin
            // sum bit enters at the MSB so the result lands in place after WIDTH shifts
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            s_d     = WIDTH'({fa_s, s_q} >> 1);
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == LAST) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
      end
   end
   assign bus.busy = state_q != IDLE;
   assign bus.done = state_q == DONE;
   assign bus.s    = s_q;
   assign bus.co   = carry_q;
endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: directed and exhaustive checks of the 4-bit serial adder
module tb_adder_serial;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   adder_serial_if #(.WIDTH(4)) bus();
   adder_serial #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tci, input logic tsub,
                        output logic [3:0] rs, output logic rco, output int lat);
      @(negedge clk);
      bus.a = ta; bus.b = tb_v; bus.ci = tci; bus.sub = tsub; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = -1; rs = 'x; rco = 1'bx;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin lat = i; rs = bus.s; rco = bus.co; end
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.s !== 4'b0000) begin failures++; $display("FAIL reset_s got=%b exp=0000", bus.s); end
      checks++; if (bus.co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", bus.co); end
   endtask

   task automatic test_add_sub;
      logic [3:0] va [6] = '{4'b0101, 4'b1111, 4'b0111, 4'b0010, 4'b1010, 4'b0101};
      logic [3:0] vb [6] = '{4'b0011, 4'b0001, 4'b0010, 4'b0111, 4'b0101, 4'b0101};
      logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       vu [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [3:0] es [6] = '{4'b1000, 4'b0000, 4'b0101, 4'b1011, 4'b0000, 4'b1111};
      logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [3:0] rs;
      logic rco;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(va[i], vb[i], vc[i], vu[i], rs, rco, lat);
         checks++; if (lat != 4) begin failures++; $display("FAIL latency_%0d got=%0d exp=4", i, lat); end
         checks++; if (rs !== es[i]) begin failures++; $display("FAIL op%0d_s got=%b exp=%b", i, rs, es[i]); end
         checks++; if (rco !== ec[i]) begin failures++; $display("FAIL op%0d_co got=%b exp=%b", i, rco, ec[i]); end
      end
   endtask

   task automatic test_ignore_start;
      int dones = 0;
      int busy_drops = 0;
      logic [3:0] rs = 'x;
      logic rco = 1'bx;
      @(negedge clk);
      bus.a = 4'b0001; bus.b = 4'b0001; bus.ci = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (dones == 0 && !bus.busy) busy_drops++;
         if (bus.done) begin dones++; rs = bus.s; rco = bus.co; end
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (dones != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
      checks++; if (busy_drops != 0) begin failures++; $display("FAIL ignore_busy_drops got=%0d exp=0", busy_drops); end
      checks++; if (rs !== 4'b0010) begin failures++; $display("FAIL ignore_s got=%b exp=0010", rs); end
      checks++; if (rco !== 1'b0) begin failures++; $display("FAIL ignore_co got=%b exp=0", rco); end
   endtask

   task automatic test_reset_mid;
      int dones = 0;
      logic [3:0] rs;
      logic rco;
      int lat;
      @(negedge clk);
      bus.a = 4'b1111; bus.b = 4'b1111; bus.ci = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", bus.done); end
      checks++; if (bus.s !== 4'b0000) begin failures++; $display("FAIL midreset_s got=%b exp=0000", bus.s); end
      checks++; if (bus.co !== 1'b0) begin failures++; $display("FAIL midreset_co got=%b exp=0", bus.co); end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
      do_op(4'b0011, 4'b0100, 1'b1, 1'b0, rs, rco, lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL midreset_latency got=%0d exp=4", lat); end
      checks++; if (rs !== 4'b1000) begin failures++; $display("FAIL midreset_s_after got=%b exp=1000", rs); end
      checks++; if (rco !== 1'b0) begin failures++; $display("FAIL midreset_co_after got=%b exp=0", rco); end
   endtask

   task automatic test_exhaustive;
      logic [3:0] rs;
      logic rco;
      logic [4:0] exp_v;
      int lat;
      int errs = 0;
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++) begin
               do_op(4'(x), 4'(y), 1'(c), 1'b0, rs, rco, lat);
               exp_v = 5'(x + y + c);
               checks++;
               if (lat != 4 || {rco, rs} !== exp_v) begin
                  failures++; errs++;
                  $display("FAIL exhaustive a=%0d b=%0d ci=%0d got=%b lat=%0d exp=%b", x, y, c, {rco, rs}, lat, exp_v);
               end
            end
      $display("exhaustive errors=%0d", errs);
   endtask

   initial begin
      test_reset;
      test_add_sub;
      test_ignore_start;
      test_reset_mid;
      test_exhaustive;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
